const_stream_gen: RTL and testbench

- Consumes the four 32-bit configuration registers exported by the team's AXI4-Lite constant-driver IP: base, increment, length, control.
- Emits an arithmetic word sequence on an AXI4-Stream master port toward the systolic-array input buffer.
- Provides a deterministic, software-programmable stimulus and fill source for array bring-up on the Ultra96 platform.

---
 rtl/const_stream_gen.sv | 182 ++++++++++++++++++
 tb/tb_const_stream_gen.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/const_stream_gen.sv
// -----------------------------------------------------------------------------
// const_stream_gen
//
// Purpose:
//   Turns the four configuration words of the AXI4-Lite constant-driver IP
//   (base, increment, length, control) into an arithmetic AXI4-Stream word
//   sequence: base, base+incr, base+2*incr, ... for `length` beats. Optional
//   repeat restarts the sequence without a bubble, and abort ends the run
//   after the beat that is currently pending. Used as a deterministic fill and
//   stimulus source for the systolic-array input buffer.
//
// Ports:
//   ACLK           single clock for all logic
//   ARESET         synchronous, active-high reset
//   cfg_base       first word of the sequence
//   cfg_incr       per-beat increment (wraps modulo 2^DATA_WIDTH)
//   cfg_len        beats per run (0 = no beats, just a done pulse)
//   cfg_ctrl       bit0 start (rising edge), bit1 repeat, bit2 abort
//   m_axis_tdata   stream data
//   m_axis_tvalid  stream valid
//   m_axis_tready  stream ready
//   m_axis_tlast   final beat of a run
//   busy           high while a run is in progress
//   done           one-cycle pulse when a run ends
//   beat_cnt       beats accepted in the current or most recent run
// -----------------------------------------------------------------------------
module const_stream_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [DATA_WIDTH-1:0] cfg_base,
  input  logic [DATA_WIDTH-1:0] cfg_incr,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [31:0]           cfg_ctrl,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  beat_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  // Control state
  state_e                state_q,  state_d;
  logic                  start_q,  start_d;
  logic                  abort_q,  abort_d;
  logic                  zpend_q,  zpend_d;   // zero-length start waiting one cycle before DONE
  logic [DATA_WIDTH-1:0] tdata_q,  tdata_d;
  logic [LEN_WIDTH-1:0]  cnt_q,    cnt_d;

  // Shadow copies of the configuration, frozen for the duration of a run
  logic [DATA_WIDTH-1:0] base_q,   base_d;
  logic [DATA_WIDTH-1:0] incr_q,   incr_d;
  logic [LEN_WIDTH-1:0]  len_q,    len_d;
  logic                  rpt_q,    rpt_d;

  logic start_edge;
  logic handshake;
  logic last_beat;
  logic abort_now;

  // Upper control bits are reserved and deliberately ignored.
  logic unused_ctrl_bits;
  assign unused_ctrl_bits = ^cfg_ctrl[31:3];

  assign start_edge = cfg_ctrl[0] & ~start_q;
  assign handshake  = (state_q == S_RUN) & m_axis_tready;
  assign last_beat  = (cnt_q == (len_q - LEN_ONE));
  // An abort seen in the same cycle as a handshake makes that beat the final one.
  assign abort_now  = cfg_ctrl[2] | abort_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d = state_q;
    start_d = cfg_ctrl[0];
    abort_d = abort_q;
    zpend_d = zpend_q;
    tdata_d = tdata_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    incr_d  = incr_q;
    len_d   = len_q;
    rpt_d   = rpt_q;

    unique case (state_q)
      S_IDLE: begin
        if (zpend_q) begin
          // Zero-length run: done lands two cycles after the start edge.
          zpend_d = 1'b0;
          state_d = S_DONE;
        end else if (start_edge) begin
          cnt_d = '0;
          if (cfg_len != '0) begin
            base_d  = cfg_base;
            incr_d  = cfg_incr;
            len_d   = cfg_len;
            rpt_d   = cfg_ctrl[1];
            abort_d = 1'b0;
            tdata_d = cfg_base;
            state_d = S_RUN;
          end else begin
            zpend_d = 1'b1;
          end
        end
      end

      S_RUN: begin
        if (cfg_ctrl[2]) begin
          abort_d = 1'b1;
        end
        if (handshake) begin
          cnt_d   = cnt_q + LEN_ONE;
          tdata_d = tdata_q + incr_q;
          if (abort_now || (last_beat && !rpt_q)) begin
            state_d = S_DONE;
          end else if (last_beat) begin
            // Repeat: restart the sequence with valid held high (no bubble).
            cnt_d   = '0;
            tdata_d = base_q;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge value of every other flop.
    if (ARESET) begin
      state_q <= S_IDLE;
      start_q <= 1'b1;   // a start bit held through reset must not fire
      abort_q <= 1'b0;
      zpend_q <= 1'b0;
      tdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      abort_q <= abort_d;
      zpend_q <= zpend_d;
      tdata_q <= tdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the shadow registers are loaded on every run start before anything
  // reads them, so they carry no reset.
  always_ff @(posedge ACLK) begin
    base_q <= base_d;
    incr_q <= incr_d;
    len_q  <= len_d;
    rpt_q  <= rpt_d;
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = (state_q == S_RUN);
  assign m_axis_tlast  = (state_q == S_RUN) & last_beat;
  assign busy          = (state_q == S_RUN);
  assign done          = (state_q == S_DONE);
  assign beat_cnt      = cnt_q;

endmodule

// File: tb/tb_const_stream_gen.sv
// -----------------------------------------------------------------------------
// tb_const_stream_gen
//
// Self-checking bench for const_stream_gen. The expected stream is computed
// arithmetically: beat k of a run carries base + (k mod len) * incr, tlast on
// (k mod len) == len-1, and a run ends after len beats (no repeat) or after
// the beat pending when abort is raised.
// -----------------------------------------------------------------------------
module tb_const_stream_gen;

  localparam int DW = 32;
  localparam int LW = 32;

  logic          clk = 1'b0;
  logic          areset;
  logic [DW-1:0] cfg_base;
  logic [DW-1:0] cfg_incr;
  logic [LW-1:0] cfg_len;
  logic [31:0]   cfg_ctrl;
  logic          tready;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic          busy;
  logic          done;
  logic [LW-1:0] beat_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  const_stream_gen #(
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW)
  ) dut (
    .ACLK          (clk),
    .ARESET        (areset),
    .cfg_base      (cfg_base),
    .cfg_incr      (cfg_incr),
    .cfg_len       (cfg_len),
    .cfg_ctrl      (cfg_ctrl),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast),
    .busy          (busy),
    .done          (done),
    .beat_cnt      (beat_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are observed and inputs driven 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tvalid"}, tvalid, 1'b0);
    check({tag, "_busy"},   busy,   1'b0);
    check({tag, "_done"},   done,   1'b0);
  endtask

  // One complete run. abort_at >= 0 raises abort once k == abort_at beats have
  // been accepted; that cycle's tready is abort_ready. noise scrambles the
  // configuration inputs and toggles the start bit while the run is active.
  task automatic do_run(input logic [31:0] base, input logic [31:0] incr,
                        input logic [31:0] len, input bit rpt, input int ready_pct,
                        input int abort_at, input bit abort_ready, input bit noise);
    int          total;
    int          k;
    bit          aborted;
    logic [31:0] idx;
    logic [31:0] exp_data;
    logic [31:0] exp_cnt;

    total    = (abort_at >= 0) ? abort_at + 1 : int'(len);
    cfg_base = base;
    cfg_incr = incr;
    cfg_len  = len;
    cfg_ctrl = 32'h0;
    tready   = 1'b0;
    step();
    cfg_ctrl = {29'b0, 1'b0, rpt, 1'b1};
    step();
    check("start_latency_tvalid", tvalid, 1'b1);

    k       = 0;
    aborted = 1'b0;
    for (int cyc = 0; cyc < 4000 && k < total; cyc++) begin
      idx      = k % len;
      exp_data = base + idx * incr;
      check("run_tvalid",   tvalid,   1'b1);
      check("run_busy",     busy,     1'b1);
      check("run_done",     done,     1'b0);
      check("run_beat_cnt", beat_cnt, idx);
      check("run_tdata",    tdata,    exp_data);
      check("run_tlast",    tlast,    (idx == len - 32'd1));

      cfg_ctrl[2] = 1'b0;
      if (abort_at >= 0 && k == abort_at && !aborted) begin
        cfg_ctrl[2] = 1'b1;
        aborted     = 1'b1;
        tready      = abort_ready;
      end else begin
        tready = ($urandom_range(0, 99) < ready_pct);
      end
      if (noise) begin
        cfg_base    = $urandom;
        cfg_incr    = $urandom;
        cfg_len     = $urandom_range(0, 7);
        cfg_ctrl[0] = 1'($urandom_range(0, 1));
      end
      if (tready) k++;
      step();
    end
    if (k < total) check("run_timeout_beats", k, total);

    cfg_ctrl[2] = 1'b0;
    tready      = 1'($urandom_range(0, 1));
    exp_cnt     = ((total - 1) % len) + 1;
    check("end_done",     done,     1'b1);
    check("end_busy",     busy,     1'b0);
    check("end_tvalid",   tvalid,   1'b0);
    check("end_tlast",    tlast,    1'b0);
    check("end_beat_cnt", beat_cnt, exp_cnt);
    step();
    check_idle("after_done");
    check("after_done_beat_cnt", beat_cnt, exp_cnt);
  endtask

  initial begin
    int          len_i;
    bit          rpt;
    int          abort_at;

    // Reset with the start bit held high.
    areset   = 1'b1;
    cfg_base = 32'h1234_5678;
    cfg_incr = 32'h1;
    cfg_len  = 32'd5;
    cfg_ctrl = 32'h1;
    tready   = 1'b1;
    step();
    step();
    check_idle("reset");
    check("reset_tlast",    tlast,    1'b0);
    check("reset_tdata",    tdata,    32'h0);
    check("reset_beat_cnt", beat_cnt, 32'h0);
    areset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_idle("start_held_after_reset");
    end

    // Basic run.
    do_run(32'h0000_0010, 32'd4, 32'd4, 1'b0, 100, -1, 1'b0, 1'b0);
    // Backpressure.
    do_run(32'h0000_0010, 32'd4, 32'd4, 1'b0, 40, -1, 1'b0, 1'b0);
    // Wrap with repeat; abort on a natural last beat, and on a middle beat.
    do_run(32'hFFFF_FFFE, 32'd1, 32'd3, 1'b1, 100, 8, 1'b1, 1'b0);
    do_run(32'hFFFF_FFFE, 32'd1, 32'd3, 1'b1, 60, 7, 1'b0, 1'b0);
    // Abort mid-run while tready is low.
    do_run(32'hA000_0000, 32'h10, 32'd100, 1'b0, 100, 5, 1'b0, 1'b0);
    // Configuration churn and start edges during the run.
    do_run(32'h0000_0100, 32'h3, 32'd9, 1'b0, 70, -1, 1'b0, 1'b1);

    // Zero length: no beats, done two cycles after the start edge.
    cfg_len  = 32'd0;
    cfg_ctrl = 32'h0;
    step();
    cfg_ctrl = 32'h1;
    step();
    check_idle("zero_len_edge_plus1");
    step();
    check("zero_len_done",     done,     1'b1);
    check("zero_len_tvalid",   tvalid,   1'b0);
    check("zero_len_beat_cnt", beat_cnt, 32'h0);
    step();
    check_idle("zero_len_after");

    // Reset in the middle of a run, with start held through the release.
    cfg_base = 32'h55;
    cfg_incr = 32'h1;
    cfg_len  = 32'd20;
    cfg_ctrl = 32'h0;
    step();
    cfg_ctrl = 32'h1;
    tready   = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("pre_reset_tvalid", tvalid, 1'b1);
    areset = 1'b1;
    step();
    check_idle("mid_run_reset");
    check("mid_run_reset_tlast", tlast, 1'b0);
    areset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_idle("post_reset_start_held");
    end

    // Randomized runs.
    for (int r = 0; r < 8; r++) begin
      len_i = int'($urandom_range(1, 12));
      rpt   = 1'($urandom_range(0, 1));
      if (rpt) abort_at = int'($urandom_range(0, 3 * len_i));
      else if ($urandom_range(0, 2) == 0) abort_at = int'($urandom_range(0, len_i - 1));
      else abort_at = -1;
      do_run($urandom, $urandom, 32'(len_i), rpt, int'($urandom_range(30, 100)),
             abort_at, 1'($urandom_range(0, 1)), 1'(r % 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
